// File: rtl/writeback.sv
// Writeback stage: commits memory-stage results into an 8 x 16 register file,
// provides two combinational read ports with same-cycle write-through, a
// combinational bypass to execute, a sticky halt flag and an optional retire
// counter.
//
// Optional feature macro: WB_RETIRE_COUNT_EN
//   defined   -> retire_count counts every committed slot (wraps at 16 bits)
//   undefined -> retire_count is tied to 0 and no counter flops exist
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   bubble_in            slot carries no instruction
//   opcode_in, tgt_in    opcode and destination register of the slot
//   result_in            ALU / link result
//   mem_data_in          data-RAM read word aligned to the slot
//   halt_in              slot is the halt instruction
//   raddr_a, raddr_b     decode read addresses
//   rdata_a, rdata_b     combinational read data (r0 reads 0)
//   fwd_valid/tgt/data   combinational bypass of the write in flight
//   halted               sticky CPU-stopped flag (registered)
//   retire_count         count of retired instructions (registered)
module writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble_in,
  input  logic [2:0]  opcode_in,
  input  logic [2:0]  tgt_in,
  input  logic [15:0] result_in,
  input  logic [15:0] mem_data_in,
  input  logic        halt_in,
  input  logic [2:0]  raddr_a,
  input  logic [2:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic        fwd_valid,
  output logic [2:0]  fwd_tgt,
  output logic [15:0] fwd_data,
  output logic        halted,
  output logic [15:0] retire_count
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpAddi = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpLui  = 3'b011;
  localparam logic [2:0] OpSw   = 3'b100;
  localparam logic [2:0] OpLw   = 3'b101;
  localparam logic [2:0] OpBeq  = 3'b110;
  localparam logic [2:0] OpJalr = 3'b111;

  logic [15:0] regs_q [8];
  logic        halted_q;
  logic        commit;
  logic        op_writes;
  logic        wen;
  logic [15:0] wdata;

  // Once halted, every slot is ignored until reset.
  assign commit = !bubble_in && !halted_q;

  always_comb begin
    op_writes = 1'b0;
    unique case (opcode_in)
      OpAdd, OpAddi, OpNand, OpLui, OpLw, OpJalr: op_writes = 1'b1;
      OpSw, OpBeq:                                op_writes = 1'b0;
      default:                                    op_writes = 1'b0;
    endcase
  end

  // The halt slot never writes; r0 targets are dropped here so r0 stays 0.
  assign wen   = commit && !halt_in && op_writes && (tgt_in != 3'd0);
  assign wdata = (opcode_in == OpLw) ? mem_data_in : result_in;

  // Register file. r0 is cleared on reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen) begin
      regs_q[tgt_in] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (commit && halt_in) begin
      halted_q <= 1'b1;
    end
  end

  // Read ports with write-through so decode sees a value in its commit cycle.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == 3'd0) begin
      rdata_a = '0;
    end else if (wen && (raddr_a == tgt_in)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (raddr_b == 3'd0) begin
      rdata_b = '0;
    end else if (wen && (raddr_b == tgt_in)) begin
      rdata_b = wdata;
    end
  end

  assign fwd_valid = wen;
  assign fwd_tgt   = tgt_in;
  assign fwd_data  = wdata;
  assign halted    = halted_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [15:0] retire_q;

  // Counts every committed slot, including non-writing, r0 and halt slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (commit) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  logic        clk;
  logic        rst_n;
  logic        bubble_in;
  logic [2:0]  opcode_in;
  logic [2:0]  tgt_in;
  logic [15:0] result_in;
  logic [15:0] mem_data_in;
  logic        halt_in;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        fwd_valid;
  logic [2:0]  fwd_tgt;
  logic [15:0] fwd_data;
  logic        halted;
  logic [15:0] retire_count;

  writeback u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble_in   (bubble_in),
    .opcode_in   (opcode_in),
    .tgt_in      (tgt_in),
    .result_in   (result_in),
    .mem_data_in (mem_data_in),
    .halt_in     (halt_in),
    .raddr_a     (raddr_a),
    .raddr_b     (raddr_b),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .fwd_valid   (fwd_valid),
    .fwd_tgt     (fwd_tgt),
    .fwd_data    (fwd_data),
    .halted      (halted),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WB_RETIRE_COUNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  localparam logic [2:0] Add = 3'd0, Addi = 3'd1, Nand = 3'd2, Lui = 3'd3;
  localparam logic [2:0] Sw  = 3'd4, Lw   = 3'd5, Beq  = 3'd6, Jalr = 3'd7;

  // Reference state: architectural registers, halt flag, retired-instruction total.
  logic [15:0] m_regs [8];
  logic        m_halted;
  int unsigned m_retired;
  bit   [7:0]  writes_tbl;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count();
    return CntOn ? 16'(m_retired % 65536) : 16'h0000;
  endfunction

  // One pipeline slot: drive on falling edge, check combinational outputs,
  // then update the model at the rising edge and check registered outputs.
  task automatic slot(input logic rst, input logic bub, input logic [2:0] op,
                      input logic [2:0] tgt, input logic [15:0] res, input logic [15:0] mem,
                      input logic hlt, input logic [2:0] ra, input logic [2:0] rb);
    bit          valid;
    bit          wr;
    logic [15:0] wd;
    logic [15:0] ea;
    logic [15:0] eb;
    @(negedge clk);
    rst_n = rst; bubble_in = bub; opcode_in = op; tgt_in = tgt;
    result_in = res; mem_data_in = mem; halt_in = hlt; raddr_a = ra; raddr_b = rb;
    #1;
    valid = !bub && !m_halted;
    wr    = valid && !hlt && writes_tbl[op] && tgt != 3'd0;
    wd    = (op == Lw) ? mem : res;
    ea    = (ra == 0) ? 16'h0 : (wr && ra == tgt) ? wd : m_regs[ra];
    eb    = (rb == 0) ? 16'h0 : (wr && rb == tgt) ? wd : m_regs[rb];
    check("fwd_valid", {15'h0, fwd_valid}, {15'h0, wr});
    if (wr) begin
      check("fwd_tgt", {13'h0, fwd_tgt}, {13'h0, tgt});
      check("fwd_data", fwd_data, wd);
    end
    check("rdata_a", rdata_a, ea);
    check("rdata_b", rdata_b, eb);
    @(posedge clk);
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_halted  = 1'b0;
      m_retired = 0;
    end else if (valid) begin
      m_retired++;
      if (hlt) m_halted = 1'b1;
      else if (wr) m_regs[tgt] = wd;
    end
    #1;
    check("halted", {15'h0, halted}, {15'h0, m_halted});
    check("retire_count", retire_count, exp_count());
  endtask

  task automatic idle_read(input logic [2:0] ra, input logic [2:0] rb);
    slot(1'b1, 1'b1, Add, 3'd0, 16'h0, 16'h0, 1'b0, ra, rb);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    writes_tbl = 8'b1010_1111;
    foreach (m_regs[i]) m_regs[i] = 16'hx;
    m_halted  = 1'b0;
    m_retired = 0;
    rst_n = 1'b0; bubble_in = 1'b1; opcode_in = '0; tgt_in = '0; result_in = '0;
    mem_data_in = '0; halt_in = 1'b0; raddr_a = '0; raddr_b = '0;

    // Reset, then every register must read zero.
    slot(1'b0, 1'b1, Add, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i += 2) idle_read(3'(i), 3'(i + 1));

    // addi r3 = 0x1234, write-through then registered.
    slot(1'b1, 1'b0, Addi, 3'd3, 16'h1234, 16'h0, 1'b0, 3'd3, 3'd0);
    check("req37_cnt", retire_count, CntOn ? 16'd1 : 16'd0);
    idle_read(3'd3, 3'd3);
    check("req37_reg3", rdata_a, 16'h1234);

    // lw takes memory data; add to r0 is dropped.
    slot(1'b1, 1'b0, Lw, 3'd5, 16'h00FF, 16'hBEEF, 1'b0, 3'd5, 3'd1);
    slot(1'b1, 1'b0, Add, 3'd0, 16'h5555, 16'h0, 1'b0, 3'd0, 3'd5);
    check("req38_r0", rdata_a, 16'h0000);
    check("req38_reg5", rdata_b, 16'hBEEF);

    // sw, beq and a bubble to r2 leave r2 alone.
    slot(1'b1, 1'b0, Add, 3'd2, 16'h0042, 16'h0, 1'b0, 3'd2, 3'd2);
    slot(1'b1, 1'b0, Sw,  3'd2, 16'hAAAA, 16'h0, 1'b0, 3'd2, 3'd0);
    slot(1'b1, 1'b0, Beq, 3'd2, 16'hAAAA, 16'h0, 1'b0, 3'd2, 3'd0);
    slot(1'b1, 1'b1, Add, 3'd2, 16'hAAAA, 16'hAAAA, 1'b1, 3'd2, 3'd0);
    check("req39_reg2", rdata_a, 16'h0042);
    check("req39_cnt", retire_count, CntOn ? 16'd6 : 16'd0);

    // Halt, then later slots are ignored.
    slot(1'b1, 1'b0, Add, 3'd1, 16'h0009, 16'h0, 1'b1, 3'd1, 3'd0);
    slot(1'b1, 1'b0, Add, 3'd1, 16'h0007, 16'h0, 1'b0, 3'd1, 3'd0);
    check("req40_halted", {15'h0, halted}, 16'h0001);
    check("req40_cnt", retire_count, CntOn ? 16'd7 : 16'd0);
    idle_read(3'd1, 3'd3);

    // Reset after halt, then reset colliding with a committing add.
    slot(1'b0, 1'b1, Add, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
    slot(1'b1, 1'b0, Add, 3'd4, 16'h1111, 16'h0, 1'b0, 3'd4, 3'd0);
    slot(1'b0, 1'b0, Add, 3'd4, 16'h2222, 16'h0, 1'b0, 3'd4, 3'd0);
    idle_read(3'd4, 3'd3);
    check("req42_reg4", rdata_a, 16'h0000);
    check("req42_cnt", retire_count, 16'h0000);

    // Randomised slots: bubbles common, halts and resets occasional.
    for (int n = 0; n < 3000; n++) begin
      slot($urandom_range(49) != 0, $urandom_range(3) == 0, 3'($urandom), 3'($urandom),
           16'($urandom), 16'($urandom), $urandom_range(39) == 0,
           3'($urandom), 3'($urandom));
    end

    // Counter wrap: 65535 committed sw slots, then one more.
    slot(1'b0, 1'b1, Add, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1; bubble_in = 1'b0; opcode_in = Sw; tgt_in = 3'd1; halt_in = 1'b0;
    repeat (65534) @(posedge clk);
    m_retired += 65534;
    slot(1'b1, 1'b0, Sw, 3'd1, 16'h0, 16'h0, 1'b0, 3'd1, 3'd2);
    check("req41_ffff", retire_count, CntOn ? 16'hFFFF : 16'h0000);
    slot(1'b1, 1'b0, Sw, 3'd1, 16'h0, 16'h0, 1'b0, 3'd1, 3'd2);
    check("req41_wrap", retire_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have a single clock `clk`, with one active edge (rising).
REQ-002 The block SHALL have reset `rst_n`: synchronous, active-low, sampled on rising `clk`.
REQ-003 Input `bubble_in` (1 bit) SHALL be high when the slot carries no instruction; it comes from the memory stage.
REQ-004 Input `opcode_in` (3 bits) SHALL carry the instruction opcode from the memory stage.
REQ-005 Input `tgt_in` (3 bits) SHALL carry the destination register index from the memory stage.
REQ-006 Input `result_in` (16 bits) SHALL carry the ALU or link result from the memory stage.
REQ-007 Input `mem_data_in` (16 bits) SHALL carry the synchronous data-RAM read word aligned to the same slot.
REQ-008 Input `halt_in` (1 bit) SHALL be high when the slot is the halt instruction; it comes from the memory stage.
REQ-009 Inputs `raddr_a` and `raddr_b` (3 bits each) SHALL be the register read addresses from decode.
REQ-010 Outputs `rdata_a` and `rdata_b` (16 bits each) SHALL be the combinational read data for those addresses.
REQ-011 Output group `fwd_valid` (1) / `fwd_tgt` (3) / `fwd_data` (16) SHALL be a combinational bypass to execute.
REQ-012 Output `halted` (1 bit) SHALL be a registered, sticky CPU-stopped flag.
REQ-013 Output `retire_count` (16 bits) SHALL be a registered count of retired instructions.

Function
REQ-014 Valid slot: define commit = !bubble_in && !halted.
REQ-015 Writing opcodes SHALL be 000 add, 001 addi, 010 nand, 011 lui, 101 lw and 111 jalr.
REQ-016 Non-writing opcodes SHALL be 100 sw and 110 beq.
REQ-017 Write enable: wen = commit && !halt_in && writing opcode && tgt_in != 0.
REQ-018 Write data: wdata = mem_data_in when opcode_in == 101, otherwise result_in.
REQ-019 Register file: 8 x 16 bits; on rising `clk` with wen, regs[tgt_in] <= wdata.
REQ-020 Writes to r0 SHALL be discarded, and r0 SHALL always read 0.
REQ-021 Read port `rdata_x`: 0 if raddr_x == 0; else wdata if wen && raddr_x == tgt_in (same-cycle write-through); else regs[raddr_x].
REQ-022 Bypass: fwd_valid = wen, fwd_tgt = tgt_in, fwd_data = wdata; fwd_tgt and fwd_data SHALL be don't-care when fwd_valid is 0.
REQ-023 Halt: on rising `clk` with commit && halt_in, `halted` SHALL be set to 1.
REQ-024 The halt slot SHALL NOT write any register.
REQ-025 Once `halted` is 1, every later slot SHALL be ignored, with no writes and no count, until reset.
REQ-026 Latency: a committed write SHALL be visible in regs one clock after its slot and on the read ports in the same cycle via write-through.
REQ-027 A bubble slot SHALL change no state, whatever the values on opcode_in, tgt_in, halt_in and the data inputs.
REQ-028 Back-to-back writes to the same register SHALL leave the later value in place, and reads SHALL return the newest value.

Reset
REQ-029 While rst_n is low at a clock edge, all regs, `halted` and `retire_count` SHALL be set to 0.
REQ-030 Reset SHALL take priority over a commit in the same cycle; that slot's write, count and halt SHALL be dropped.
REQ-031 Reset asserted mid-run, including after halt, SHALL return the block to the empty, running state on the next edge.
REQ-032 During reset, combinational outputs SHALL still follow their equations; `rdata` SHALL reflect the cleared regs after the edge.

Configuration
REQ-033 Macro `WB_RETIRE_COUNT_EN` SHALL control the retire counter.
REQ-034 With `WB_RETIRE_COUNT_EN` defined, `retire_count` SHALL increment by 1 on each commit, including sw, beq, r0-target and halt slots.
REQ-035 With `WB_RETIRE_COUNT_EN` defined, `retire_count` SHALL wrap from 0xFFFF to 0x0000.
REQ-036 With `WB_RETIRE_COUNT_EN` undefined, `retire_count` SHALL be tied to constant 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-037 Scenario: after reset, slot addi, tgt=3, result=0x1234, bubble=0 -> fwd_valid=1 and rdata_a(raddr=3)=0x1234 in the same cycle; regs[3]=0x1234 on the next cycle; retire_count=1.
REQ-038 Scenario: lw, tgt=5, result=0x00FF, mem_data=0xBEEF -> regs[5]=0xBEEF; then add, tgt=0, result=0x5555 -> r0 reads 0 and fwd_valid=0.
REQ-039 Scenario: sw and beq slots with tgt=2, result=0xAAAA, followed by a bubble slot with opcode add, tgt=2 -> regs[2] unchanged; retire_count +2 (counter build).
REQ-040 Scenario: halt slot, then add, tgt=1, result=7 -> halted=1 and stays 1; regs[1] unchanged; retire_count incremented once, for the halt only.
REQ-041 Scenario: preload retire_count to 0xFFFF by 65535 commits, then one more commit -> retire_count=0x0000.
REQ-042 Scenario: rst_n low coincident with a committing add to tgt=4 -> regs[4]=0, retire_count=0, halted=0.
REQ-043 Scenario: counter-off build -> retire_count=0 at all times.
